// File: rtl/nic8_pkg.sv
// Shared nic8 definitions used by the run sequencer, the CPU core and the panel decode.
//   DEFAULT_ADDR_W : default program RAM address width
//   rc_state_e     : run_control state encoding (shown on the panel LEDs)
//   rc_cpu_owns_bus: states in which the CPU, not the loader, owns the RAM port
package nic8_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 8;

  typedef enum logic [2:0] {
    RC_IDLE   = 3'd0,
    RC_LOAD   = 3'd1,
    RC_CLEAR  = 3'd2,
    RC_RUN    = 3'd3,
    RC_HALTED = 3'd4,
    RC_STEP   = 3'd5
  } rc_state_e;

  function automatic logic rc_cpu_owns_bus(input rc_state_e s);
    return (s == RC_RUN) || (s == RC_HALTED) || (s == RC_STEP);
  endfunction

endpackage

// File: rtl/byte_loader.sv
// Program-load datapath: RAM write address counter, remaining-byte counter and write strobe.
//   clk_i        : system clock
//   rst_ni       : synchronous active-low reset
//   start_i      : accepted load start; clears the address and latches len_i
//   len_i        : byte count, 0 meaning 2^ADDR_W
//   active_i     : sequencer is in its LOAD state (byte stream is being accepted)
//   byte_valid_i : loader byte present
//   addr_o       : RAM write address
//   write_bar_o  : active-low RAM write strobe, combinational on byte_valid_i
//   last_o       : the byte transferred this cycle (if any) is the final one
module byte_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] len_i,
  input  logic              active_i,
  input  logic              byte_valid_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              write_bar_o,
  output logic              last_o
);

  // One extra bit so a zero length can stand for a full 2^ADDR_W image.
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              xfer;

  assign xfer = active_i & byte_valid_i;

  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if (start_i) begin
      addr_d = '0;
      rem_d  = (len_i == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, len_i};
    end else if (xfer) begin
      // Address wraps naturally at 2^ADDR_W.
      addr_d = addr_q + ADDR_W'(1);
      rem_d  = rem_q - (ADDR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  assign addr_o      = addr_q;
  assign write_bar_o = ~xfer;
  assign last_o      = (rem_q == (ADDR_W + 1)'(1));

endmodule

// File: rtl/run_control.sv
// nic8 run sequencer: loads a program image into RAM from a byte stream, then clears, runs,
// halts or single-steps the CPU by gating its clock enable, and arbitrates the RAM port.
//   clk, resetBar          : clock, synchronous active-low reset
//   loadStart, loadLen     : begin a load of loadLen bytes (0 = 2^ADDR_W)
//   byteValid/byteData/byteReady : loader byte stream
//   run, halt, step        : front-panel command pulses
//   cpuHaltReq             : CPU asks to halt (jump-to-self)
//   ramAddr/ramData/ramWriteBar : loader side of the RAM write port
//   busGrantCpu            : 1 = CPU owns the RAM port
//   cpuClockEn, cpuResetBar: CPU advance enable and active-low reset
//   cycleCount             : enabled CPU cycles since the last clear
//   state                  : current state encoding for the panel LEDs
module run_control #(
  parameter int unsigned ADDR_W       = nic8_pkg::DEFAULT_ADDR_W,
  parameter int unsigned CLEAR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              resetBar,
  input  logic              loadStart,
  input  logic [ADDR_W-1:0] loadLen,
  input  logic              byteValid,
  input  logic [7:0]        byteData,
  output logic              byteReady,
  input  logic              run,
  input  logic              halt,
  input  logic              step,
  input  logic              cpuHaltReq,
  output logic [ADDR_W-1:0] ramAddr,
  output logic [7:0]        ramData,
  output logic              ramWriteBar,
  output logic              busGrantCpu,
  output logic              cpuClockEn,
  output logic              cpuResetBar,
  output logic [15:0]       cycleCount,
  output logic [2:0]        state
);

  import nic8_pkg::*;

  localparam int unsigned ClrW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  rc_state_e       state_q, state_d;
  logic [ClrW-1:0] clr_cnt_q, clr_cnt_d;
  logic [15:0]     cycle_count_q, cycle_count_d;

  logic in_load;
  logic load_accept;
  logic load_last;
  logic clr_done;
  logic cpu_enabled;

  assign in_load     = (state_q == RC_LOAD);
  // loadStart outranks every other command in both states that honour it.
  assign load_accept = loadStart & ((state_q == RC_IDLE) | (state_q == RC_HALTED));
  assign clr_done    = (clr_cnt_q == ClrW'(CLEAR_CYCLES - 1));
  assign cpu_enabled = (state_q == RC_RUN) | (state_q == RC_STEP);

  byte_loader #(
    .ADDR_W (ADDR_W)
  ) u_byte_loader (
    .clk_i        (clk),
    .rst_ni       (resetBar),
    .start_i      (load_accept),
    .len_i        (loadLen),
    .active_i     (in_load),
    .byte_valid_i (byteValid),
    .addr_o       (ramAddr),
    .write_bar_o  (ramWriteBar),
    .last_o       (load_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RC_IDLE: begin
        if (loadStart) state_d = RC_LOAD;
        else if (run)  state_d = RC_CLEAR;
      end
      RC_LOAD: begin
        if (byteValid && load_last) state_d = RC_IDLE;
      end
      RC_CLEAR: begin
        if (clr_done) state_d = RC_RUN;
      end
      RC_RUN: begin
        if (halt || cpuHaltReq) state_d = RC_HALTED;
      end
      RC_HALTED: begin
        if (loadStart) state_d = RC_LOAD;
        else if (run)  state_d = RC_RUN;
        else if (step) state_d = RC_STEP;
      end
      RC_STEP: state_d = RC_HALTED;
      default: state_d = RC_IDLE;
    endcase
  end

  always_comb begin
    clr_cnt_d = (state_q == RC_CLEAR) ? clr_cnt_q + ClrW'(1) : '0;

    // Zeroed as CLEAR is entered so the count already reads 0 in the first CLEAR cycle.
    cycle_count_d = cycle_count_q;
    if (state_d == RC_CLEAR) begin
      cycle_count_d = '0;
    end else if (cpu_enabled) begin
      cycle_count_d = cycle_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetBar) begin
      state_q       <= RC_IDLE;
      clr_cnt_q     <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign byteReady   = in_load;
  assign ramData     = byteData;
  assign busGrantCpu = rc_cpu_owns_bus(state_q);
  assign cpuResetBar = rc_cpu_owns_bus(state_q);
  assign cpuClockEn  = cpu_enabled;
  assign cycleCount  = cycle_count_q;
  assign state       = state_q;

endmodule
